// File: rtl/seg7_scan_if.sv
// Load-side and display-side signals of the 4-digit 7-segment scanner.
interface seg7_scan_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    // load is a one-cycle strobe with no ready: every cycle it is high is captured, the last one wins.
    modport master (output value, dp_in, blank, load, input seg, dp, an, frame_done);
    modport slave  (input value, dp_in, blank, load, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit hex display driver; tick is a clock enable, new values
// are double-buffered and only become visible at a frame boundary.
module seg7_scan #(
    parameter int PRESCALE = 4
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       tick,
    seg7_scan_if.slave bus,
    output logic       o_dbg_state
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_digit, w_digit_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic        w_wrap;

    logic [15:0] r_sh_value, r_act_value, w_act_value;
    logic [3:0]  r_sh_dp, r_act_dp, w_act_dp;
    logic [3:0]  r_sh_blank, r_act_blank, w_act_blank;
    logic [3:0]  w_nibble;

    logic [3:0]  r_an, w_an_nx;
    logic [6:0]  r_seg, w_seg_nx;
    logic        r_dp, w_dp_nx;
    logic        r_frame_done;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit;
        w_cnt_nx   = r_cnt;
        w_wrap     = 1'b0;
        if (tick) begin
            case (r_state)
                SHOW: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nx = GAP;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    w_state_nx = SHOW;
                    w_digit_nx = r_digit + 2'd1;
                    w_wrap     = (r_digit == 2'd3);
                end
                default: w_state_nx = SHOW;
            endcase
        end
    end

    // A load coinciding with the wrap bypasses the shadow so it is shown in the frame now starting.
    always_comb begin
        w_act_value = r_act_value;
        w_act_dp    = r_act_dp;
        w_act_blank = r_act_blank;
        if (w_wrap) begin
            if (bus.load) begin
                w_act_value = bus.value;
                w_act_dp    = bus.dp_in;
                w_act_blank = bus.blank;
            end else begin
                w_act_value = r_sh_value;
                w_act_dp    = r_sh_dp;
                w_act_blank = r_sh_blank;
            end
        end
    end

    always_comb begin
        w_nibble = w_act_value[3:0];
        case (w_digit_nx)
            2'd1:    w_nibble = w_act_value[7:4];
            2'd2:    w_nibble = w_act_value[11:8];
            2'd3:    w_nibble = w_act_value[15:12];
            default: w_nibble = w_act_value[3:0];
        endcase
        w_an_nx  = 4'hF;
        w_seg_nx = r_seg;
        w_dp_nx  = r_dp;
        if (w_state_nx == SHOW) begin
            w_seg_nx = hex7(w_nibble);
            w_dp_nx  = ~w_act_dp[w_digit_nx];
            if (!w_act_blank[w_digit_nx]) w_an_nx = ~(4'b0001 << w_digit_nx);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SHOW;
            r_digit <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_digit <= w_digit_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_value   <= 16'h0000;
            r_sh_dp      <= 4'h0;
            r_sh_blank   <= 4'h0;
            r_act_value  <= 16'h0000;
            r_act_dp     <= 4'h0;
            r_act_blank  <= 4'h0;
            r_an         <= 4'hF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.load) begin
                r_sh_value <= bus.value;
                r_sh_dp    <= bus.dp_in;
                r_sh_blank <= bus.blank;
            end
            r_act_value  <= w_act_value;
            r_act_dp     <= w_act_dp;
            r_act_blank  <= w_act_blank;
            r_an         <= w_an_nx;
            r_seg        <= w_seg_nx;
            r_dp         <= w_dp_nx;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for the Nexys 3 4-digit 7-segment display. Shows a 16-bit hex value, e.g. the current nonce or a status word from the miner core.
- Sits directly downstream of the clock divider. It runs on mclk and uses the divider's output pulse as a clock enable (tick), not as a clock.
- Provides tear-free updates: a new value is latched on load but only goes on the display at a frame boundary.

Parameters:
- PRESCALE, 4, number of tick pulses each digit is lit per slot. Must be ≥ 2; counter width is clog2(PRESCALE).

Ports:
- mclk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  clock enable from the divider; high for 1 mclk cycle at most every other cycle
- value  input  16  hex value to display; value[3:0] goes to digit 0 (rightmost)
- dp_in  input  4  decimal-point enables, active-high, one per digit; sampled with value
- blank  input  4  per-digit blank mask, active-high; sampled with value
- load  input  1  1-cycle strobe; captures value, dp_in and blank into the shadow register
- seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal-point cathode, active-low
- an  output  4  anodes, active-low; an[0] is the rightmost digit
- frame_done  output  1  1-mclk pulse when the digit index wraps from 3 to 0

Behaviour:
- Reset is asynchronous and active-low: one clock (mclk); rst_n is asynchronous and active-low.
- Values while rst_n is low:
  - an=4'hF, seg=7'h7F, dp=1, frame_done=0.
  - State=SHOW, digit index=0, prescale count=0.
  - Shadow and active registers (value, dp, blank) = 0.
- All outputs are registered. They change on the same mclk edge as the state change, with no extra pipeline latency.
- State machine:
  - SHOW, tick=1, count<PRESCALE-1: count+1.
  - SHOW, tick=1, count=PRESCALE-1: go to GAP, count=0, an=4'hF (anti-ghosting blank).
  - GAP, tick=1: go to SHOW, digit=(digit+1) mod 4.
    - If the digit was 3: pulse frame_done and copy shadow into active on that same edge.
  - tick=0: no state or count change.
- Slot timing: PRESCALE ticks in SHOW plus 1 tick in GAP. Frame = 4*(PRESCALE+1) ticks.
- Outputs while in SHOW:
  - an = one-hot-low on the current digit.
  - an stays 4'hF if the active blank bit for that digit is set.
  - seg = hex decode of the active nibble; dp = ~active dp bit.
- Outputs while in GAP: an=4'hF; seg and dp hold their previous values.
- Hex decode (gfedcba, hex), digits 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Shadow register loading:
  - load captures inputs on any mclk cycle, regardless of tick.
  - Multiple loads within one frame: the last one wins.
  - load on the same edge as the 3→0 wrap: the new inputs go directly to active (bypass) and are shown from that frame on.
- A blanked digit still uses its full slot; the frame period does not change.
- rst_n asserted mid-frame: outputs go to their reset values immediately. The first SHOW of digit 0 starts once rst_n is released. Digit 0 shows 0 (seg=40) because the active register was cleared.
- tick held high continuously (out of spec) must not break the design: every cycle counts as a tick.

Test Plan:
1. Reset release, no load, tick every 2nd mclk, PRESCALE=4:
   - an sequence E,F,D,F,B,F,7,F; each non-F phase lasts 8 mclk, each F phase 2 mclk.
   - seg=40 on every digit; frame_done pulses every 40 mclk.
2. Load value=16'h1A2F, dp_in=4'b0100, blank=0 mid-frame:
   - Display is unchanged until the next wrap.
   - Next frame shows seg 0E/an=E, 24/D, 08/B, 79/7.
   - dp=0 only while an=B.
3. load pulsed on the exact wrap edge with value=16'hBEEF:
   - The very next digit 0 shows seg=0E; no frame of the old value follows.
4. blank=4'b1010 with value=16'h8888:
   - an never goes to D or 7; seg=00 during the an=E and an=B slots.
   - frame_done period is still 40 mclk.
5. Hold tick=0 for 100 mclk mid-slot:
   - an, seg and count are frozen; the sequence resumes exactly where it stopped.
6. Pull rst_n low for 3 mclk in the middle of digit 2:
   - an=F, seg=7F and dp=1 asynchronously (before the next mclk edge).
   - After release, the sequence restarts at an=E with seg=40.
